// File: rtl/fm_pkg.sv
// Shared types and constants for the FM phase modulator and related DDS-side blocks.
package fm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fm_state_e;

    localparam int unsigned PHASE_W = 32;
    localparam int unsigned SAT_W   = 34;

    // Clamp a signed sum into the unsigned phase-increment range [0, 2^PHASE_W-1].
    function automatic logic [PHASE_W-1:0] sat_phase(input logic signed [SAT_W-1:0] s);
        logic [PHASE_W-1:0] r;
        if (s[SAT_W-1]) begin
            r = '0;
        end else if (|s[SAT_W-2:PHASE_W]) begin
            r = '1;
        end else begin
            r = s[PHASE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Rate divider: divcnt counts 0..CLKDIV-1; tick is high while divcnt sits at CLKDIV-1.
module tick_divider #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [CNT_W-1:0] divcnt;

    // tick is registered one count early so it lines up with divcnt==CLKDIV-1
    always_ff @(posedge clock) begin
        if (reset) begin
            divcnt <= '0;
            tick   <= 1'b0;
        end else begin
            divcnt <= (divcnt == CNT_W'(CLKDIV - 1)) ? '0 : divcnt + CNT_W'(1);
            tick   <= (divcnt == CNT_W'(CLKDIV - 2));
        end
    end

endmodule

// File: rtl/fm_phase_modulator.sv
// Audio-to-phase-increment front end of the FM DDS: sample handshake, linear
// interpolation at the tick rate, deviation gain and saturating carrier offset.
module fm_phase_modulator
    import fm_pkg::*;
#(
    parameter int unsigned NBITS_SAMPLE = 16,
    parameter int unsigned NBITS_GAIN   = 16,
    parameter int unsigned GAIN_FRAC    = 8,
    parameter int unsigned INTERP_LOG2  = 6,
    parameter int unsigned CLKDIV       = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NBITS_SAMPLE-1:0] audio_in,
    input  logic                    audio_valid,
    output logic                    audio_ready,
    input  logic [PHASE_W-1:0]      center_inc,
    input  logic [NBITS_GAIN-1:0]   dev_gain,
    output logic                    enableclk,
    output logic [PHASE_W-1:0]      phaseinc,
    output logic                    underrun
);

    localparam int unsigned STEP_W   = NBITS_SAMPLE + 1;
    localparam int unsigned ACC_W    = NBITS_SAMPLE + INTERP_LOG2 + 1;
    localparam int unsigned INTERP_W = NBITS_SAMPLE + 1;
    localparam int unsigned GAIN_W   = NBITS_GAIN + 1;
    localparam int unsigned PROD_W   = INTERP_W + GAIN_W;
    localparam logic [INTERP_LOG2-1:0] K_LAST = '1;

    logic tick;

    tick_divider #(
        .CLKDIV (CLKDIV)
    ) u_tick_divider (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    fm_state_e                      state,      state_nxt;
    logic signed [NBITS_SAMPLE-1:0] target,     target_nxt;
    logic signed [STEP_W-1:0]       step,       step_nxt;
    logic signed [ACC_W-1:0]        acc,        acc_nxt;
    logic [INTERP_LOG2-1:0]         k,          k_nxt;
    logic                           pend_valid, pend_valid_nxt;
    logic signed [NBITS_SAMPLE-1:0] pend_data,  pend_data_nxt;
    logic                           underrun_nxt;
    logic                           audio_ready_nxt;
    logic                           consume;
    logic                           accept;

    assign accept = audio_valid & audio_ready;

    // Interpolator FSM: segment sequencing, pending-slot consumption, underrun detection
    always_comb begin
        state_nxt    = state;
        target_nxt   = target;
        step_nxt     = step;
        acc_nxt      = acc;
        k_nxt        = k;
        underrun_nxt = underrun;
        consume      = 1'b0;

        if (tick) begin
            unique case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        consume    = 1'b1;
                        state_nxt  = ST_RUN;
                        target_nxt = pend_data;
                        step_nxt   = STEP_W'(pend_data);
                        acc_nxt    = '0;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    k_nxt = k + INTERP_LOG2'(1);
                    if (k == K_LAST) begin
                        // snap exactly onto the segment end to avoid drift
                        acc_nxt = ACC_W'(target) <<< INTERP_LOG2;
                        if (pend_valid) begin
                            consume    = 1'b1;
                            state_nxt  = ST_RUN;
                            target_nxt = pend_data;
                            step_nxt   = STEP_W'(pend_data) - STEP_W'(target);
                        end else begin
                            state_nxt    = ST_HOLD;
                            step_nxt     = '0;
                            underrun_nxt = 1'b1;
                        end
                    end else if (state == ST_RUN) begin
                        acc_nxt = acc + ACC_W'(step);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        pend_valid_nxt  = (pend_valid & ~consume) | accept;
        pend_data_nxt   = accept ? audio_in : pend_data;
        audio_ready_nxt = ~pend_valid_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            target      <= '0;
            step        <= '0;
            acc         <= '0;
            k           <= '0;
            pend_valid  <= 1'b0;
            pend_data   <= '0;
            underrun    <= 1'b0;
            audio_ready <= 1'b1;
        end else begin
            state       <= state_nxt;
            target      <= target_nxt;
            step        <= step_nxt;
            acc         <= acc_nxt;
            k           <= k_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_data   <= pend_data_nxt;
            underrun    <= underrun_nxt;
            audio_ready <= audio_ready_nxt;
        end
    end

    logic signed [INTERP_W-1:0] interp;
    logic signed [GAIN_W-1:0]   gain_s;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   dev;
    logic signed [SAT_W-1:0]    sum;
    logic                       prod_vld;

    assign interp = INTERP_W'(acc >>> INTERP_LOG2);
    assign gain_s = $signed({1'b0, dev_gain});
    assign dev    = prod >>> GAIN_FRAC;
    assign sum    = SAT_W'($signed({1'b0, center_inc})) + SAT_W'(dev);

    // Output pipeline: product one cycle after the acc update, clamped sum one cycle later
    always_ff @(posedge clock) begin
        if (reset) begin
            enableclk <= 1'b0;
            prod_vld  <= 1'b0;
            prod      <= '0;
            phaseinc  <= '0;
        end else begin
            enableclk <= tick;
            prod_vld  <= enableclk;
            if (enableclk) begin
                prod <= PROD_W'(interp) * PROD_W'(gain_s);
            end
            if (prod_vld) begin
                phaseinc <= sat_phase(sum);
            end
        end
    end

endmodule
